pu_msp430_trace_buffer: RTL and testbench

Parametrised instruction-trace recorder for the MSP430 core.
- Captures one entry per decoded instruction (PC, opcode or IRQ number, cycle length of the previous instruction) into a circular buffer of DEPTH entries.
- Supports PC-match trigger with programmable post-trigger depth, then freezes for readout.
- Sits beside the core on decode/ir/pc/irq signals; usable in testbench and in debug-unit builds.

---
 rtl/pu_msp430_trace_buffer.sv | 230 +++++++++++++++++++++++
 tb/tb_pu_msp430_trace_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_msp430_trace_buffer.sv
// pu_msp430_trace_buffer
// Instruction-trace recorder for the MSP430 core. Each decoded instruction
// (PC, opcode or IRQ number, cycle length of the previous instruction) is
// stored in a circular buffer. A PC-match or forced trigger starts a
// post-trigger window of POST_DEPTH entries. After that window the buffer
// freezes and is read out oldest-first over a valid/ready port.
// Optional build macro: PU_MSP430_TRACE_TSTAMP_EN adds a 32-bit free-running
// timestamp to each entry, placed in the most significant bits of rd_data.
module pu_msp430_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int POST_DEPTH = 4,
    parameter int PC_W       = 16,
    parameter int CYC_W      = 8,
    localparam int AW        = $clog2(DEPTH),
`ifdef PU_MSP430_TRACE_TSTAMP_EN
    localparam int TS_W      = 32,
`else
    localparam int TS_W      = 0,
`endif
    localparam int ENTRY_W   = TS_W + 1 + CYC_W + 16 + PC_W
) (
    input  logic               mclk,
    input  logic               puc_rst,
    input  logic               decode,
    input  logic [15:0]        ir,
    input  logic [PC_W-1:0]    pc,
    input  logic               irq_detect,
    input  logic [3:0]         irq_num,
    input  logic               arm,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic [PC_W-1:0]    trig_mask,
    input  logic               force_trig,
    input  logic               rd_start,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [1:0]         trc_state,
    output logic [AW:0]        trc_count,
    output logic [31:0]        inst_number
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0] POST_LAST = (AW+1)'(POST_DEPTH);

    // Trace storage; contents are deliberately not reset
    logic [ENTRY_W-1:0] r_mem [DEPTH];

    state_t             r_state;
    logic [1:0]         r_trc_state;
    logic               r_rd_valid;
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [AW:0]        r_count;
    logic [AW:0]        r_remaining;
    logic [AW:0]        r_post_cnt;
    logic [CYC_W-1:0]   r_cyc_cnt;
    logic [31:0]        r_inst_number;

    logic               w_match;
    logic               w_capture;
    logic               w_wr_en;
    logic [AW:0]        w_post_next;
    logic [15:0]        w_op;
    logic [ENTRY_W-1:0] w_entry;

    // Trigger condition: masked PC compare on a decode, or a forced trigger
    assign w_match     = (decode && (((pc ^ trig_pc) & trig_mask) == '0)) || force_trig;
    assign w_capture   = (r_state == ST_ARMED) || (r_state == ST_POST);
    // A simultaneous arm restarts the buffer, so that decode is dropped
    assign w_wr_en     = decode && w_capture && !arm;
    assign w_post_next = r_post_cnt + 1'b1;
    assign w_op        = irq_detect ? {12'h000, irq_num} : ir;

`ifdef PU_MSP430_TRACE_TSTAMP_EN
    logic [31:0] r_tstamp;

    // Free-running timestamp, one tick per mclk
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_tstamp <= '0;
        end else begin
            r_tstamp <= r_tstamp + 32'd1;
        end
    end

    assign w_entry = {r_tstamp, irq_detect, r_cyc_cnt, w_op, pc};
`else
    assign w_entry = {irq_detect, r_cyc_cnt, w_op, pc};
`endif

    // Entry write into the circular buffer while capturing
    always_ff @(posedge mclk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    // Cycles since the previous decode, saturating
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_cyc_cnt <= '0;
        end else if (decode) begin
            r_cyc_cnt <= CYC_W'(1);
        end else if (r_cyc_cnt != '1) begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
        end
    end

    // Decode counter, running in every state and wrapping at 2^32
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_inst_number <= '0;
        end else if (decode) begin
            r_inst_number <= r_inst_number + 32'd1;
        end
    end

    // Capture/trigger/readout control with registered status outputs
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state     <= ST_IDLE;
            r_trc_state <= 2'd0;
            r_rd_valid  <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_post_cnt  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
                if (r_count != DEPTH_C) begin
                    r_count <= r_count + 1'b1;
                end
            end

            if (arm) begin
                // Restart from any state; also aborts a readout in progress
                r_state     <= ST_ARMED;
                r_trc_state <= 2'd1;
                r_rd_valid  <= 1'b0;
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_count     <= '0;
                r_remaining <= '0;
                r_post_cnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                    end
                    ST_ARMED: begin
                        if (w_match) begin
                            if (w_wr_en) begin
                                // The triggering decode is post entry 1
                                r_post_cnt <= (AW+1)'(1);
                                if (POST_DEPTH == 1) begin
                                    r_state     <= ST_DONE;
                                    r_trc_state <= 2'd3;
                                end else begin
                                    r_state     <= ST_POST;
                                    r_trc_state <= 2'd2;
                                end
                            end else begin
                                r_post_cnt  <= '0;
                                r_state     <= ST_POST;
                                r_trc_state <= 2'd2;
                            end
                        end
                    end
                    ST_POST: begin
                        if (w_wr_en) begin
                            r_post_cnt <= w_post_next;
                            if (w_post_next == POST_LAST) begin
                                r_state     <= ST_DONE;
                                r_trc_state <= 2'd3;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (rd_start) begin
                            if (r_count == '0) begin
                                r_state     <= ST_IDLE;
                                r_trc_state <= 2'd0;
                            end else begin
                                // A full buffer has wrapped: oldest entry sits at wptr
                                r_state     <= ST_READ;
                                r_rd_valid  <= 1'b1;
                                r_rptr      <= (r_count == DEPTH_C) ? r_wptr : '0;
                                r_remaining <= r_count;
                            end
                        end
                    end
                    ST_READ: begin
                        if (r_rd_valid && rd_ready) begin
                            r_rptr      <= r_rptr + 1'b1;
                            r_remaining <= r_remaining - 1'b1;
                            if (r_remaining == (AW+1)'(1)) begin
                                r_state     <= ST_IDLE;
                                r_trc_state <= 2'd0;
                                r_rd_valid  <= 1'b0;
                                r_count     <= '0;
                            end
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_trc_state <= 2'd0;
                        r_rd_valid  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Read data follows rptr directly; forced to zero outside readout
    assign rd_data     = r_rd_valid ? r_mem[r_rptr] : '0;
    assign rd_valid    = r_rd_valid;
    assign trc_state   = r_trc_state;
    assign trc_count   = r_count;
    assign inst_number = r_inst_number;

endmodule

// File: tb/tb_pu_msp430_trace_buffer.sv
// Testbench for pu_msp430_trace_buffer (DEPTH=8, POST_DEPTH=4).
// The reference model keeps the captured trace as a queue of entries and
// derives cycle lengths from absolute decode times.
module tb_pu_msp430_trace_buffer;

    localparam int DEPTH = 8;
    localparam int POST  = 4;
`ifdef PU_MSP430_TRACE_TSTAMP_EN
    localparam int EW = 32 + 1 + 8 + 16 + 16;
`else
    localparam int EW = 1 + 8 + 16 + 16;
`endif

    logic          mclk = 1'b0;
    logic          puc_rst = 1'b1;
    logic          decode = 1'b0;
    logic [15:0]   ir = '0;
    logic [15:0]   pc = '0;
    logic          irq_detect = 1'b0;
    logic [3:0]    irq_num = '0;
    logic          arm = 1'b0;
    logic [15:0]   trig_pc = '0;
    logic [15:0]   trig_mask = '0;
    logic          force_trig = 1'b0;
    logic          rd_start = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [EW-1:0] rd_data;
    logic [1:0]    trc_state;
    logic [3:0]    trc_count;
    logic [31:0]   inst_number;

    int total = 0;
    int bad = 0;

    // Reference model: 0 idle, 1 armed, 2 post, 3 done, 4 read
    int            m_st = 0;
    int            m_post = 0;
    int            m_edge = 0;
    int            m_last = 0;
    logic [31:0]   m_inst = '0;
    logic [EW-1:0] m_q[$];
    logic [EW-1:0] m_rdq[$];

    pu_msp430_trace_buffer #(
        .DEPTH(DEPTH), .POST_DEPTH(POST), .PC_W(16), .CYC_W(8)
    ) dut (
        .mclk(mclk), .puc_rst(puc_rst), .decode(decode), .ir(ir), .pc(pc),
        .irq_detect(irq_detect), .irq_num(irq_num), .arm(arm),
        .trig_pc(trig_pc), .trig_mask(trig_mask), .force_trig(force_trig),
        .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .trc_state(trc_state), .trc_count(trc_count),
        .inst_number(inst_number)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One mclk: check read port, advance model at the edge, check status after
    task automatic tick();
        logic [EW-1:0] ent;
        bit            match;
        int            cyc;
        int            exp_st;
        if (m_st == 4) begin
            chk("rd_valid", 128'(rd_valid), 128'(1));
            chk("rd_data", 128'(rd_data), 128'(m_rdq[0]));
        end else begin
            chk("rd_valid_idle", 128'(rd_valid), 128'(0));
        end
        cyc = m_edge - m_last;
        if (cyc > 255) cyc = 255;
`ifdef PU_MSP430_TRACE_TSTAMP_EN
        ent = {32'(m_edge), irq_detect, 8'(cyc), (irq_detect ? {12'h000, irq_num} : ir), pc};
`else
        ent = {irq_detect, 8'(cyc), (irq_detect ? {12'h000, irq_num} : ir), pc};
`endif
        match = (decode && (((pc ^ trig_pc) & trig_mask) == 16'h0)) || force_trig;
        @(posedge mclk);
        if (arm) begin
            m_st = 1; m_post = 0;
            m_q.delete(); m_rdq.delete();
        end else if (m_st == 1 || m_st == 2) begin
            if (decode) begin
                m_q.push_back(ent);
                if (m_q.size() > DEPTH) void'(m_q.pop_front());
            end
            if (m_st == 1 && match) begin
                m_st = 2;
                m_post = decode ? 1 : 0;
            end else if (m_st == 2 && decode) begin
                m_post++;
            end
            if (m_st == 2 && m_post == POST) m_st = 3;
        end else if (m_st == 3) begin
            if (rd_start) begin
                if (m_q.size() == 0) m_st = 0;
                else begin m_st = 4; m_rdq = m_q; end
            end
        end else if (m_st == 4) begin
            if (rd_ready) begin
                void'(m_rdq.pop_front());
                if (m_rdq.size() == 0) begin m_st = 0; m_q.delete(); end
            end
        end
        if (decode) begin m_inst++; m_last = m_edge; end
        m_edge++;
        #1;
        decode = 0; arm = 0; force_trig = 0; rd_start = 0; irq_detect = 0;
        exp_st = (m_st == 4) ? 3 : m_st;
        chk("trc_state", 128'(trc_state), 128'(exp_st));
        chk("trc_count", 128'(trc_count), 128'(m_q.size()));
        chk("inst_number", 128'(inst_number), 128'(m_inst));
    endtask

    task automatic do_reset();
        puc_rst = 1;
        #2;
        chk("rst_rd_valid", 128'(rd_valid), 128'(0));
        chk("rst_rd_data", 128'(rd_data), 128'(0));
        chk("rst_state", 128'(trc_state), 128'(0));
        chk("rst_count", 128'(trc_count), 128'(0));
        chk("rst_inst", 128'(inst_number), 128'(0));
        @(posedge mclk);
        #1;
        puc_rst = 0;
        decode = 0; arm = 0; force_trig = 0; rd_start = 0; irq_detect = 0; rd_ready = 0;
        m_st = 0; m_post = 0; m_edge = 0; m_last = 0; m_inst = '0;
        m_q.delete(); m_rdq.delete();
    endtask

    task automatic dec(input logic [15:0] p, input logic [15:0] op, input logic irq, input logic [3:0] num);
        decode = 1; pc = p; ir = op; irq_detect = irq; irq_num = num;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Readout; mode 0 toggles ready starting at 1, mode 1 holds ready, mode 2 random
    task automatic readout(input int mode, output int beats);
        beats = 0;
        rd_start = 1;
        tick();
        rd_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 0; c < 200 && m_st == 4; c++) begin
            if (rd_ready) beats++;
            tick();
            if (mode == 0) rd_ready = ~rd_ready;
            else if (mode == 2) rd_ready = 1'($urandom_range(0, 1));
        end
        rd_ready = 0;
        chk("readout_end_state", 128'(trc_state), 128'(0));
        chk("readout_end_count", 128'(trc_count), 128'(0));
    endtask

    initial begin
        int beats;
        int sel;
        #12;
        do_reset();

        // Reset in the middle of a capture
        trig_pc = 16'hFFFF; trig_mask = 16'hFFFF;
        arm = 1; tick();
        dec(16'h0100, 16'h4303, 0, 0);
        dec(16'h0102, 16'h4303, 0, 0);
        do_reset();

        // Trigger at 0x100A with four post entries, ten decodes
        trig_pc = 16'h100A; trig_mask = 16'hFFFF;
        arm = 1; tick();
        for (int i = 0; i < 10; i++) dec(16'h1000 + 16'(2 * i), 16'h4000 + 16'(i), 0, 0);
        chk("t2_state", 128'(trc_state), 128'(3));
        chk("t2_count", 128'(trc_count), 128'(8));
        chk("t2_inst", 128'(inst_number), 128'(10));
        readout(0, beats);
        chk("t3_beats", 128'(beats), 128'(8));

        // Cycle spacing, saturation and IRQ entries; mask 0 triggers at once
        trig_mask = 16'h0000;
        arm = 1; tick();
        dec(16'h2000, 16'h1234, 1, 4'hE);
        idle(2);
        dec(16'h2002, 16'h5678, 0, 0);
        idle(299);
        dec(16'h2004, 16'h9ABC, 0, 0);
        idle(2);
        dec(16'h2006, 16'hDEF0, 1, 4'h3);
        chk("t4_state", 128'(trc_state), 128'(3));
        readout(1, beats);
        chk("t4_beats", 128'(beats), 128'(4));

        // Re-arm during POST, arm+force together, then a forced trigger
        trig_pc = 16'h3000; trig_mask = 16'hFFFF;
        arm = 1; tick();
        dec(16'h2FFE, 16'h0001, 0, 0);
        dec(16'h3000, 16'h0002, 0, 0);
        rd_start = 1; tick();
        dec(16'h3002, 16'h0003, 0, 0);
        arm = 1; tick();
        chk("t6_rearm_state", 128'(trc_state), 128'(1));
        chk("t6_rearm_count", 128'(trc_count), 128'(0));
        arm = 1; force_trig = 1; tick();
        chk("t6_armforce_state", 128'(trc_state), 128'(1));
        force_trig = 1; tick();
        chk("t6_force_state", 128'(trc_state), 128'(2));
        for (int i = 0; i < 4; i++) begin
            dec(16'h4000 + 16'(2 * i), 16'h7000 + 16'(i), 0, 0);
            idle(2);
        end
        chk("t6_done_state", 128'(trc_state), 128'(3));
        // Arm while reading aborts the readout
        rd_start = 1; tick();
        rd_ready = 1; idle(2); rd_ready = 0;
        arm = 1; tick();
        chk("t6_abort_valid", 128'(rd_valid), 128'(0));

        // Randomized captures and readouts
        for (int r = 0; r < 20; r++) begin
            sel = $urandom_range(0, 3);
            trig_mask = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'hFFF0 : (sel == 2) ? 16'h0000 : 16'($urandom);
            trig_pc = 16'($urandom_range(0, 63));
            arm = 1; tick();
            for (int c = 0; c < 80 && m_st != 3; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    decode = 1; pc = 16'($urandom_range(0, 63)); ir = 16'($urandom);
                    irq_detect = ($urandom_range(0, 7) == 0); irq_num = 4'($urandom);
                end
                if ($urandom_range(0, 39) == 0) force_trig = 1;
                if ($urandom_range(0, 19) == 0) rd_start = 1;
                tick();
                if ($urandom_range(0, 29) == 0) idle(260);
            end
            for (int c = 0; c < 40 && m_st != 3; c++) begin
                force_trig = (c == 0);
                decode = 1; pc = 16'($urandom); ir = 16'($urandom);
                tick();
            end
            chk("rnd_done", 128'(trc_state), 128'(3));
            readout(2, beats);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
